// File: rtl/demux_sequencer.sv
// Sweeps one captured data word across a run of demux outputs,
// presenting one (I, S) delivery per cycle with pause and abort.
module demux_sequencer #(
  parameter int NUMOUT = 8,
  parameter int SW     = 3,
  parameter int IW     = 8
) (
  input  logic          CK,
  input  logic          CLR,
  input  logic          GO,
  input  logic          HOLD,
  input  logic          ABORT,
  input  logic [IW-1:0] D,
  input  logic [SW-1:0] FIRST,
  input  logic [SW:0]   CNT,
  output logic [IW-1:0] I,
  output logic [SW-1:0] S,
  output logic          EN,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [SW:0] LN   = (SW+1)'(NUMOUT);
  localparam logic [SW:0] LAST = (SW+1)'(NUMOUT - 1);
  localparam logic [SW:0] ONE  = (SW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_t;

  state_t        r_st;
  logic [SW:0]   r_rem;
  logic [IW-1:0] r_i;
  logic [SW-1:0] r_s;
  logic          r_en;
  logic          r_busy;
  logic          r_done;

  logic          w_start;
  logic [SW-1:0] w_first;
  logic [SW:0]   w_len;
  logic [SW-1:0] w_s_nxt;
  logic          w_last;

  assign w_start = GO & ~ABORT & (CNT != '0);
  assign w_first = ({1'b0, FIRST} >= LN) ? '0 : FIRST;
  assign w_len   = (CNT > LN) ? LN : CNT;
  assign w_last  = (r_rem == ONE);
  // wrap keeps S inside the populated outputs
  assign w_s_nxt = ({1'b0, r_s} == LAST) ? '0 : r_s + 1'b1;

  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      r_st   <= ST_IDLE;
      r_rem  <= '0;
      r_i    <= '0;
      r_s    <= '0;
      r_en   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_st)
        ST_IDLE: begin
          if (w_start) begin
            r_st   <= ST_RUN;
            r_i    <= D;
            r_s    <= w_first;
            r_rem  <= w_len;
            r_en   <= 1'b1;
            r_busy <= 1'b1;
          end
        end
        ST_RUN: begin
          if (ABORT) begin
            r_st   <= ST_IDLE;
            r_s    <= '0;
            r_rem  <= '0;
            r_en   <= 1'b0;
            r_busy <= 1'b0;
          end else if (HOLD) begin
            r_st <= ST_PAUSE;
            r_en <= 1'b0;
          end else if (w_last) begin
            r_st   <= ST_IDLE;
            r_s    <= '0;
            r_rem  <= '0;
            r_en   <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_rem <= r_rem - ONE;
            r_s   <= w_s_nxt;
          end
        end
        ST_PAUSE: begin
          if (ABORT) begin
            r_st   <= ST_IDLE;
            r_s    <= '0;
            r_rem  <= '0;
            r_en   <= 1'b0;
            r_busy <= 1'b0;
          end else if (!HOLD) begin
            r_st <= ST_RUN;
            r_en <= 1'b1;
          end
        end
        default: begin
          r_st   <= ST_IDLE;
          r_s    <= '0;
          r_rem  <= '0;
          r_en   <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign I    = r_i;
  assign S    = r_s;
  assign EN   = r_en;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: tb/tb_demux_sequencer.sv
// Random and directed checks of demux_sequencer against a
// queue-based sweep model; second instance covers NUMOUT=6.
module tb_demux_sequencer;

  logic       CK = 1'b0;
  logic       CLR = 1'b0;
  logic       GO = 1'b0, HOLD = 1'b0, ABORT = 1'b0;
  logic [7:0] D = '0;
  logic [2:0] FIRST = '0;
  logic [3:0] CNT = '0;
  logic [7:0] I;
  logic [2:0] S;
  logic       EN, BUSY, DONE;

  logic       GO6 = 1'b0;
  logic       HOLD6 = 1'b0, ABORT6 = 1'b0;
  logic [7:0] D6 = '0;
  logic [2:0] FIRST6 = '0;
  logic [3:0] CNT6 = '0;
  logic [7:0] I6;
  logic [2:0] S6;
  logic       EN6, BUSY6, DONE6;

  int checks = 0;
  int errors = 0;

  bit         m_act, m_pau, m_done;
  logic [7:0] m_i;
  int         pend[$];

  demux_sequencer dut (
    .CK(CK), .CLR(CLR), .GO(GO), .HOLD(HOLD), .ABORT(ABORT),
    .D(D), .FIRST(FIRST), .CNT(CNT),
    .I(I), .S(S), .EN(EN), .BUSY(BUSY), .DONE(DONE)
  );

  demux_sequencer #(.NUMOUT(6), .SW(3), .IW(8)) dut6 (
    .CK(CK), .CLR(CLR), .GO(GO6), .HOLD(HOLD6), .ABORT(ABORT6),
    .D(D6), .FIRST(FIRST6), .CNT(CNT6),
    .I(I6), .S(S6), .EN(EN6), .BUSY(BUSY6), .DONE(DONE6)
  );

  always #5 CK = ~CK;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_act = 0;
    m_pau = 0;
    m_done = 0;
    m_i = '0;
    pend.delete();
  endtask

  // sweep = queue of output indices still to be delivered
  task automatic m_step();
    m_done = 0;
    if (!m_act) begin
      if (GO && !ABORT && CNT != 0) begin
        int n;
        n = (int'(CNT) > 8) ? 8 : int'(CNT);
        pend.delete();
        for (int k = 0; k < n; k++)
          pend.push_back((int'(FIRST) + k) % 8);
        m_i = D;
        m_act = 1;
        m_pau = 0;
      end
    end else if (ABORT) begin
      m_act = 0;
      m_pau = 0;
      pend.delete();
    end else if (m_pau) begin
      if (!HOLD) m_pau = 0;
    end else if (HOLD) begin
      m_pau = 1;
    end else begin
      void'(pend.pop_front());
      if (pend.size() == 0) begin
        m_act = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic compare(string t);
    chk({t, ".EN"}, 32'(EN), 32'(m_act && !m_pau));
    chk({t, ".BUSY"}, 32'(BUSY), 32'(m_act));
    chk({t, ".S"}, 32'(S), m_act ? 32'(pend[0]) : 32'd0);
    chk({t, ".I"}, 32'(I), 32'(m_i));
    chk({t, ".DONE"}, 32'(DONE), 32'(m_done));
  endtask

  task automatic cyc(input bit go, input bit hold, input bit abort,
                     input logic [7:0] d, input logic [2:0] f,
                     input logic [3:0] c, input string t);
    GO = go;
    HOLD = hold;
    ABORT = abort;
    D = d;
    FIRST = f;
    CNT = c;
    @(posedge CK);
    m_step();
    #1;
    compare(t);
  endtask

  task automatic sweep6(input logic [2:0] f, input logic [3:0] c,
                        input int start, input int n);
    int sum_en;
    GO6 = 1'b1;
    FIRST6 = f;
    CNT6 = c;
    D6 = 8'h3C;
    @(posedge CK);
    #1;
    GO6 = 1'b0;
    sum_en = 0;
    for (int k = 0; k < n; k++) begin
      chk("n6.EN", 32'(EN6), 32'd1);
      chk("n6.S", 32'(S6), 32'((start + k) % 6));
      chk("n6.I", 32'(I6), 32'h3C);
      @(posedge CK);
      #1;
    end
    chk("n6.DONE", 32'(DONE6), 32'd1);
    chk("n6.Sidle", 32'(S6), 32'd0);
  endtask

  initial begin
    int en_cnt;
    m_reset();
    #1;
    chk("rst.EN", 32'(EN), 32'd0);
    chk("rst.BUSY", 32'(BUSY), 32'd0);
    chk("rst.S", 32'(S), 32'd0);
    chk("rst.I", 32'(I), 32'd0);
    chk("rst.DONE", 32'(DONE), 32'd0);
    #2 CLR = 1'b1;

    cyc(1, 0, 0, 8'hA5, 3'd2, 4'd3, "bas0");
    chk("bas.S0", 32'(S), 32'd2);
    chk("bas.I0", 32'(I), 32'hA5);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "bas1");
    chk("bas.S1", 32'(S), 32'd3);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "bas2");
    chk("bas.S2", 32'(S), 32'd4);
    chk("bas.EN2", 32'(EN), 32'd1);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "bas3");
    chk("bas.DONE", 32'(DONE), 32'd1);
    chk("bas.BUSY", 32'(BUSY), 32'd0);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "bas4");

    cyc(1, 0, 0, 8'h11, 3'd6, 4'd4, "wrp0");
    chk("wrp.S0", 32'(S), 32'd6);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "wrp1");
    chk("wrp.S1", 32'(S), 32'd7);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "wrp2");
    chk("wrp.S2", 32'(S), 32'd0);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "wrp3");
    chk("wrp.S3", 32'(S), 32'd1);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "wrp4");
    chk("wrp.DONE", 32'(DONE), 32'd1);

    cyc(1, 0, 0, 8'h5A, 3'd1, 4'd5, "hld0");
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "hld1");
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "hld2");
    chk("hld.S3a", 32'(S), 32'd3);
    cyc(0, 1, 0, 8'h00, 3'd0, 4'd0, "hld3");
    chk("hld.ENp", 32'(EN), 32'd0);
    chk("hld.Sp", 32'(S), 32'd3);
    cyc(0, 1, 0, 8'h00, 3'd0, 4'd0, "hld4");
    chk("hld.BUSYp", 32'(BUSY), 32'd1);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "hld5");
    chk("hld.S3b", 32'(S), 32'd3);
    chk("hld.EN3b", 32'(EN), 32'd1);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "hld6");
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "hld7");
    chk("hld.S5", 32'(S), 32'd5);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "hld8");
    chk("hld.DONE", 32'(DONE), 32'd1);

    cyc(1, 0, 0, 8'h77, 3'd3, 4'd12, "big0");
    en_cnt = 0;
    for (int k = 0; k < 20 && !DONE; k++) begin
      if (EN) en_cnt++;
      cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "big");
    end
    chk("big.deliveries", 32'(en_cnt), 32'd8);
    chk("big.DONE", 32'(DONE), 32'd1);

    cyc(1, 0, 0, 8'h99, 3'd4, 4'd0, "zro0");
    chk("zro.BUSY", 32'(BUSY), 32'd0);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "zro1");
    chk("zro.DONE", 32'(DONE), 32'd0);

    cyc(1, 0, 0, 8'h42, 3'd0, 4'd6, "abt0");
    cyc(0, 1, 0, 8'h00, 3'd0, 4'd0, "abt1");
    cyc(1, 1, 1, 8'h00, 3'd0, 4'd3, "abt2");
    chk("abt.EN", 32'(EN), 32'd0);
    chk("abt.S", 32'(S), 32'd0);
    chk("abt.BUSY", 32'(BUSY), 32'd0);
    chk("abt.DONE", 32'(DONE), 32'd0);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "abt3");

    cyc(1, 0, 0, 8'hC3, 3'd5, 4'd6, "clr0");
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "clr1");
    CLR = 1'b0;
    #1;
    m_reset();
    chk("clr.EN", 32'(EN), 32'd0);
    chk("clr.BUSY", 32'(BUSY), 32'd0);
    chk("clr.S", 32'(S), 32'd0);
    chk("clr.I", 32'(I), 32'd0);
    chk("clr.DONE", 32'(DONE), 32'd0);
    #1 CLR = 1'b1;
    for (int k = 0; k < 8; k++)
      cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "clrpost");
    cyc(1, 0, 0, 8'hE7, 3'd7, 4'd1, "clrgo");
    chk("clrgo.EN", 32'(EN), 32'd1);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "clrgo1");

    cyc(1, 0, 0, 8'h0F, 3'd0, 4'd2, "b2b0");
    cyc(1, 0, 0, 8'hF0, 3'd0, 4'd2, "b2b1");
    chk("b2b.S1", 32'(S), 32'd1);
    cyc(1, 0, 0, 8'hF0, 3'd4, 4'd2, "b2b2");
    chk("b2b.gapEN", 32'(EN), 32'd0);
    chk("b2b.gapDONE", 32'(DONE), 32'd1);
    cyc(1, 0, 0, 8'hF0, 3'd4, 4'd2, "b2b3");
    chk("b2b.EN2", 32'(EN), 32'd1);
    chk("b2b.S2", 32'(S), 32'd4);
    chk("b2b.I2", 32'(I), 32'hF0);
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "b2b4");
    cyc(0, 0, 0, 8'h00, 3'd0, 4'd0, "b2b5");

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        CLR = 1'b0;
        #1;
        m_reset();
        compare("rndclr");
        #1 CLR = 1'b1;
      end
      cyc($urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 15) == 0,
          8'($urandom), 3'($urandom_range(0, 7)),
          4'($urandom_range(0, 15)), "rnd");
    end

    GO = 1'b0;
    HOLD = 1'b0;
    ABORT = 1'b0;
    sweep6(3'd7, 4'd2, 0, 2);
    @(posedge CK);
    #1;
    sweep6(3'd4, 4'd9, 4, 6);
    @(posedge CK);
    #1;
    sweep6(3'd5, 4'd3, 5, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
